param_rr_arbiter: RTL and testbench

//  N-way registered arbiter, successor to the 3-input combinational fixed-priority arbiter.

---
 rtl/arb_pkg.sv | 13 +
 rtl/param_rr_arbiter_if.sv | 32 +++
 rtl/arb_rot_prio_enc.sv | 44 ++++
 rtl/param_rr_arbiter.sv | 109 ++++++++++
 tb/tb_param_rr_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the parameterised round-robin arbiter.
package arb_pkg;

    typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_e;

    typedef enum logic {ST_IDLE = 1'b0, ST_GRANTED = 1'b1} arb_state_e;

    // Width of an index/counter that must be at least one bit even for tiny ranges.
    function automatic int clog2_min1(input int value);
        return (value > 2) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/param_rr_arbiter_if.sv
// Request/grant bundle between N clients (master) and the arbiter (slave).
interface param_rr_arbiter_if
    import arb_pkg::*;
#(
    parameter int N = 3
);

    localparam int IDW = clog2_min1(N);

    arb_mode_e      mode;
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;

    modport master (
        output mode,
        output req,
        input  grant,
        input  grant_valid,
        input  grant_id
    );

    modport slave (
        input  mode,
        input  req,
        output grant,
        output grant_valid,
        output grant_id
    );

endinterface

// File: rtl/arb_rot_prio_enc.sv
// Rotating priority encoder: first set bit of (req & ~exclude) searching upward
// from start_i and wrapping modulo N.
module arb_rot_prio_enc
    import arb_pkg::*;
#(
    parameter  int N   = 3,
    localparam int IDW = clog2_min1(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] start_i,
    input  logic [N-1:0]   exclude_i,
    output logic           found_o,
    output logic [N-1:0]   winner_o,
    output logic [IDW-1:0] winner_idx_o
);

    logic [N-1:0]   masked;
    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;

    // Doubling the vector turns the wrap-around search into a plain right shift.
    always_comb begin
        int idx;
        idx          = 0;
        masked       = req_i & ~exclude_i;
        doubled      = {masked, masked};
        rotated      = N'(doubled >> start_i);
        found_o      = 1'b0;
        winner_o     = '0;
        winner_idx_o = '0;
        for (int k = 0; k < N; k++) begin
            if (!found_o && rotated[k]) begin
                found_o = 1'b1;
                idx     = int'(start_i) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                winner_idx_o = IDW'(idx);
                winner_o     = N'(1) << idx;
            end
        end
    end

endmodule

// File: rtl/param_rr_arbiter.sv
// Registered N-way arbiter with runtime fixed/round-robin selection, optional
// grant locking and a cap on consecutive locked cycles.
module param_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 3,
    parameter int LOCK     = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    param_rr_arbiter_if.slave bus
);

    localparam int IDW = clog2_min1(N);
    localparam int HW  = clog2_min1(MAX_HOLD + 1);

    arb_state_e     state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic           grant_valid_q, grant_valid_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]  hold_cnt_q, hold_cnt_d;

    logic           ownerReq;
    logic           otherReq;
    logic           capHit;
    logic           keepGrant;
    logic           capForced;
    logic [IDW-1:0] arbStart;
    logic [N-1:0]   arbExclude;
    logic           winFound;
    logic [N-1:0]   winOneHot;
    logic [IDW-1:0] winIdx;

    // A cap-forced handover only happens when someone else is waiting;
    // otherwise the owner keeps the grant and the counter just saturates.
    always_comb begin
        ownerReq   = |(bus.req & grant_q);
        otherReq   = |(bus.req & ~grant_q);
        capHit     = (MAX_HOLD != 0) && (int'(hold_cnt_q) >= MAX_HOLD - 1);
        keepGrant  = (state_q == ST_GRANTED) && (LOCK != 0) && ownerReq && !(capHit && otherReq);
        capForced  = (state_q == ST_GRANTED) && (LOCK != 0) && ownerReq && capHit && otherReq;
        arbStart   = (bus.mode == ARB_RR) ? rr_ptr_q : '0;
        arbExclude = capForced ? grant_q : '0;
    end

    arb_rot_prio_enc #(
        .N (N)
    ) u_enc (
        .req_i        (bus.req),
        .start_i      (arbStart),
        .exclude_i    (arbExclude),
        .found_o      (winFound),
        .winner_o     (winOneHot),
        .winner_idx_o (winIdx)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        rr_ptr_d      = rr_ptr_q;
        hold_cnt_d    = hold_cnt_q;

        if (keepGrant) begin
            if (hold_cnt_q != {HW{1'b1}}) begin
                hold_cnt_d = hold_cnt_q + HW'(1);
            end
        end else if (winFound) begin
            state_d       = ST_GRANTED;
            grant_d       = winOneHot;
            grant_valid_d = 1'b1;
            grant_id_d    = winIdx;
            hold_cnt_d    = '0;
            rr_ptr_d      = (int'(winIdx) == N - 1) ? '0 : winIdx + IDW'(1);
        end else begin
            state_d       = ST_IDLE;
            grant_d       = '0;
            grant_valid_d = 1'b0;
            grant_id_d    = '0;
            hold_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            rr_ptr_q      <= '0;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            rr_ptr_q      <= rr_ptr_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_id    = grant_id_q;

endmodule

// File: tb/tb_param_rr_arbiter.sv
// Directed bench for param_rr_arbiter: unlocked, locked (cap 4) and N=1 instances,
// per-cycle invariant checks and a sticky-random soak with a starvation bound.
module tb_param_rr_arbiter;
    import arb_pkg::*;

    localparam int MAXH         = 4;
    localparam int STARVE_BOUND = (3 - 1) * MAXH + 3;

    localparam logic [2:0] FIX_REQ [6] = '{3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};
    localparam logic [2:0] FIX_EXP [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b001};
    localparam logic [2:0] RR_EXP  [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    localparam logic [2:0] LCK_EXP [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    localparam logic [2:0] SW_EXP  [9] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010,
                                          3'b010, 3'b010, 3'b010, 3'b001};
    localparam logic       N1_SEQ  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    bit   chkEn = 1'b0;

    param_rr_arbiter_if #(.N(3)) ifL0 ();
    param_rr_arbiter_if #(.N(3)) ifL1 ();
    param_rr_arbiter_if #(.N(1)) ifN1 ();

    param_rr_arbiter #(.N(3), .LOCK(0), .MAX_HOLD(MAXH)) dutL0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifL0.slave)
    );

    param_rr_arbiter #(.N(3), .LOCK(1), .MAX_HOLD(MAXH)) dutL1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifL1.slave)
    );

    param_rr_arbiter #(.N(1), .LOCK(1), .MAX_HOLD(MAXH)) dutN1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifN1.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] req, input arb_mode_e mode);
        ifL0.req  = req;
        ifL0.mode = mode;
        ifL1.req  = req;
        ifL1.mode = mode;
    endtask

    function automatic logic [1:0] idOf(input logic [2:0] g);
        logic [1:0] id;
        id = 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (g[i]) id = 2'(i);
        end
        return id;
    endfunction

    task automatic checkGrant(input string tag, input bit useL1, input logic [2:0] expGrant);
        logic [2:0] g;
        logic       v;
        logic [1:0] id;
        g  = useL1 ? ifL1.grant       : ifL0.grant;
        v  = useL1 ? ifL1.grant_valid : ifL0.grant_valid;
        id = useL1 ? ifL1.grant_id    : ifL0.grant_id;
        checkOutput({tag, "_grant"}, {5'b0, g},  {5'b0, expGrant});
        checkOutput({tag, "_valid"}, {7'b0, v},  {7'b0, |expGrant});
        checkOutput({tag, "_id"},    {6'b0, id}, {6'b0, idOf(expGrant)});
    endtask

    task automatic checkInv(input string tag, input logic [2:0] g, input logic v, input logic [1:0] id);
        checkOutput({tag, "_onehot0"}, {7'b0, $onehot0(g)}, 8'd1);
        checkOutput({tag, "_valid"},   {7'b0, v},           {7'b0, |g});
        checkOutput({tag, "_id"},      {6'b0, id},          {6'b0, idOf(g)});
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Structural invariants hold every cycle regardless of the directed sequence.
    always @(negedge clk) begin
        if (chkEn) begin
            checkInv("invL0", ifL0.grant, ifL0.grant_valid, ifL0.grant_id);
            checkInv("invL1", ifL1.grant, ifL1.grant_valid, ifL1.grant_id);
        end
    end

    initial begin
        logic [2:0] reqCur;
        arb_mode_e  modeCur;
        int         waitCnt [3];
        int         maxWait;

        ifN1.req  = 1'b0;
        ifN1.mode = ARB_FIXED;
        applyStimulus(3'b111, ARB_FIXED);

        // Reset held two cycles with all requests asserted.
        rst_n = 1'b0;
        tick();
        chkEn = 1'b1;
        checkGrant("rst_c1", 1'b1, 3'b000);
        tick();
        checkGrant("rst_c2", 1'b1, 3'b000);
        rst_n = 1'b1;
        tick();
        checkGrant("rst_first", 1'b1, 3'b001);

        // Fixed priority without locking.
        doReset();
        for (int v = 0; v < 6; v++) begin
            applyStimulus(FIX_REQ[v], ARB_FIXED);
            for (int c = 0; c < 4; c++) begin
                tick();
                checkGrant($sformatf("fix_v%0d_c%0d", v, c), 1'b0, FIX_EXP[v]);
            end
        end

        // Round-robin without locking rotates every cycle.
        doReset();
        applyStimulus(3'b111, ARB_RR);
        for (int c = 0; c < 6; c++) begin
            tick();
            checkGrant($sformatf("rr_c%0d", c), 1'b0, RR_EXP[c]);
        end

        // Locked round-robin: each owner is cut off after four cycles.
        doReset();
        applyStimulus(3'b111, ARB_RR);
        for (int c = 0; c < 16; c++) begin
            tick();
            checkGrant($sformatf("lock_c%0d", c), 1'b1, LCK_EXP[c / 4]);
        end

        // Lone requester keeps the grant past the cap.
        doReset();
        applyStimulus(3'b001, ARB_RR);
        for (int c = 0; c < 10; c++) begin
            tick();
            checkGrant($sformatf("solo_c%0d", c), 1'b1, 3'b001);
        end

        // Mode switch during a held grant only affects the next arbitration.
        doReset();
        applyStimulus(3'b111, ARB_RR);
        tick();
        checkGrant("sw_c0", 1'b1, SW_EXP[0]);
        applyStimulus(3'b111, ARB_FIXED);
        for (int c = 1; c < 9; c++) begin
            tick();
            checkGrant($sformatf("sw_c%0d", c), 1'b1, SW_EXP[c]);
        end

        // Owner releases while others wait: handover with no idle gap, then idle.
        doReset();
        applyStimulus(3'b010, ARB_RR);
        tick();
        checkGrant("rel_own", 1'b1, 3'b010);
        applyStimulus(3'b111, ARB_RR);
        tick();
        checkGrant("rel_hold", 1'b1, 3'b010);
        applyStimulus(3'b101, ARB_RR);
        tick();
        checkGrant("rel_next", 1'b1, 3'b100);
        applyStimulus(3'b000, ARB_RR);
        tick();
        checkGrant("rel_idle", 1'b1, 3'b000);

        // Reset in the middle of a locked grant clears lock and pointer.
        doReset();
        applyStimulus(3'b100, ARB_RR);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkGrant($sformatf("mid_c%0d", c), 1'b1, 3'b100);
        end
        rst_n = 1'b0;
        tick();
        checkGrant("mid_rst", 1'b1, 3'b000);
        rst_n = 1'b1;
        applyStimulus(3'b111, ARB_RR);
        tick();
        checkGrant("mid_after", 1'b1, 3'b001);

        // Single-client instance just delays its request by one cycle.
        doReset();
        for (int c = 0; c < 6; c++) begin
            ifN1.req = N1_SEQ[c];
            tick();
            checkOutput($sformatf("n1_grant_c%0d", c), {7'b0, ifN1.grant},       {7'b0, N1_SEQ[c]});
            checkOutput($sformatf("n1_valid_c%0d", c), {7'b0, ifN1.grant_valid}, {7'b0, N1_SEQ[c]});
            checkOutput($sformatf("n1_id_c%0d", c),    {7'b0, ifN1.grant_id},    8'd0);
        end

        // Sticky random soak; starvation is only bounded in round-robin mode.
        doReset();
        reqCur  = 3'b000;
        maxWait = 0;
        for (int b = 0; b < 3; b++) waitCnt[b] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(7) == 0) reqCur[b] = ~reqCur[b];
            end
            if (cyc < 4000) begin
                modeCur = ($urandom_range(1) == 1) ? ARB_RR : ARB_FIXED;
            end else begin
                modeCur = ARB_RR;
            end
            applyStimulus(reqCur, modeCur);
            tick();
            checkOutput("soak_legal", {5'b0, ifL1.grant & ~reqCur}, 8'h00);
            if (cyc >= 4000) begin
                for (int b = 0; b < 3; b++) begin
                    if (reqCur[b] && !ifL1.grant[b]) begin
                        waitCnt[b]++;
                    end else begin
                        waitCnt[b] = 0;
                    end
                    if (waitCnt[b] > maxWait) maxWait = waitCnt[b];
                end
            end
        end
        checkOutput("soak_starve", {7'b0, maxWait <= STARVE_BOUND}, 8'd1);

        chkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
